// File: rtl/collision_game_state_ctrl_pkg.sv
// Shared encodings and widths for the collision game state controller.
// The state constants keep the legacy Head.v numbering so existing renderers still decode GAME_STATE.
package collision_game_state_ctrl_pkg;

   localparam int GAME_STATE_LENGTH = 2;
   localparam int LIVES_LENGTH      = 2;

   typedef logic [GAME_STATE_LENGTH-1:0] game_state_t;
   typedef logic [LIVES_LENGTH-1:0]      lives_t;

   localparam game_state_t STATE_IDLE    = 2'd0;
   localparam game_state_t STATE_PLAYING = 2'd1;
   localparam game_state_t STATE_HIT     = 2'd2;
   localparam game_state_t STATE_OVER    = 2'd3;

endpackage

// File: rtl/collision_game_state_ctrl_if.sv
// Frame-rate handshake between the overlap judges, the game controller and the renderer.
// master = stimulus/judge side, slave = the controller.
interface collision_game_state_ctrl_if
   import collision_game_state_ctrl_pkg::*;
#(
   parameter int NUM_BLOCKS  = 4,
   parameter int SCORE_WIDTH = 10
);

   logic                   FRAME_TICK;
   logic                   START_KEY;
   logic [NUM_BLOCKS-1:0]  IS_OVERLAPPING_VEC;
   logic [NUM_BLOCKS-1:0]  BLOCK_PASSED_VEC;
   game_state_t            GAME_STATE;
   logic                   SCROLL_EN;
   logic [SCORE_WIDTH-1:0] SCORE;
   lives_t                 LIVES;
   logic                   FLASH;
   logic                   GAME_OVER_PULSE;

   modport master (
      output FRAME_TICK, START_KEY, IS_OVERLAPPING_VEC, BLOCK_PASSED_VEC,
      input  GAME_STATE, SCROLL_EN, SCORE, LIVES, FLASH, GAME_OVER_PULSE
   );

   modport slave (
      input  FRAME_TICK, START_KEY, IS_OVERLAPPING_VEC, BLOCK_PASSED_VEC,
      output GAME_STATE, SCROLL_EN, SCORE, LIVES, FLASH, GAME_OVER_PULSE
   );

endinterface

// File: rtl/collision_game_state_ctrl_overlap_persist_filter.sv
// Counts consecutive sampled frames with any overlap; confirm fires on the tick that completes the run,
// combinationally, so the controller can react in the same cycle and keep its outputs one register deep.
module overlap_persist_filter #(
   parameter int unsigned HIT_CONFIRM = 2
) (
   input  logic CLK,
   input  logic RESET,
   input  logic overlap,
   input  logic frame_tick,
   input  logic clear,
   output logic confirm
);

   localparam logic [2:0] LAST_COUNT = 3'(HIT_CONFIRM - 1);

   logic [2:0] persist;

   assign confirm = frame_tick && !clear && overlap && (persist == LAST_COUNT);

   always_ff @(posedge CLK) begin
      if (RESET || clear) begin
         persist <= '0;
      end else if (frame_tick) begin
         if (!overlap || confirm) persist <= '0;
         else                     persist <= persist + 3'd1;
      end
   end

endmodule

// File: rtl/collision_game_state_ctrl.sv
// Game state machine: lives, saturating score, scroll enable and invincibility flash,
// driven by the per-frame overlap and pass vectors from the block judges.
module collision_game_state_ctrl
   import collision_game_state_ctrl_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS        = 4,
   parameter int unsigned HIT_CONFIRM       = 2,
   parameter int unsigned INVINCIBLE_FRAMES = 60,
   parameter int unsigned INIT_LIVES        = 3,
   parameter int unsigned SCORE_WIDTH       = 10,
   parameter int unsigned FLASH_PERIOD      = 8
) (
   input logic                        CLK,
   input logic                        RESET,
   collision_game_state_ctrl_if.slave bus
);

   game_state_t            state;
   logic                   scroll_en;
   logic [SCORE_WIDTH-1:0] score;
   lives_t                 lives;
   logic                   flash;
   logic                   over_pulse;
   logic [7:0]             inv_cnt;
   logic [7:0]             flash_cnt;
   logic                   start_q;
   logic                   start_edge;
   logic                   confirm;
   logic [SCORE_WIDTH:0]   passed;
   logic [SCORE_WIDTH:0]   score_sum;
   logic [SCORE_WIDTH-1:0] score_next;

   assign start_edge = bus.START_KEY && !start_q;

   overlap_persist_filter #(.HIT_CONFIRM(HIT_CONFIRM)) u_filter (
      .CLK        (CLK),
      .RESET      (RESET),
      .overlap    (|bus.IS_OVERLAPPING_VEC),
      .frame_tick (bus.FRAME_TICK),
      .clear      (state != STATE_PLAYING),
      .confirm    (confirm)
   );

   always_comb begin
      passed = '0;
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
         passed = passed + (SCORE_WIDTH+1)'(bus.BLOCK_PASSED_VEC[i]);
      end
      score_sum  = {1'b0, score} + passed;
      score_next = score_sum[SCORE_WIDTH] ? '1 : score_sum[SCORE_WIDTH-1:0];
   end

   // start_q follows the key even during reset, so a key held through reset needs a release first.
   always_ff @(posedge CLK) begin
      start_q <= bus.START_KEY;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= STATE_IDLE;
         scroll_en  <= 1'b0;
         score      <= '0;
         lives      <= LIVES_LENGTH'(INIT_LIVES);
         flash      <= 1'b0;
         over_pulse <= 1'b0;
         inv_cnt    <= '0;
         flash_cnt  <= '0;
      end else begin
         over_pulse <= 1'b0;
         case (state)
            STATE_IDLE: begin
               if (start_edge) begin
                  state     <= STATE_PLAYING;
                  scroll_en <= 1'b1;
                  lives     <= LIVES_LENGTH'(INIT_LIVES);
                  score     <= '0;
                  inv_cnt   <= '0;
                  flash_cnt <= '0;
               end
            end
            STATE_PLAYING: begin
               if (bus.FRAME_TICK) begin
                  score <= score_next;
                  if (confirm) begin
                     lives <= lives - 2'd1;
                     if (lives == 2'd1) begin
                        state      <= STATE_OVER;
                        scroll_en  <= 1'b0;
                        over_pulse <= 1'b1;
                     end else begin
                        state     <= STATE_HIT;
                        inv_cnt   <= 8'(INVINCIBLE_FRAMES);
                        flash_cnt <= '0;
                        flash     <= 1'b0;
                     end
                  end
               end
            end
            STATE_HIT: begin
               if (bus.FRAME_TICK) begin
                  score   <= score_next;
                  inv_cnt <= inv_cnt - 8'd1;
                  if (inv_cnt == 8'd1) begin
                     state     <= STATE_PLAYING;
                     flash     <= 1'b0;
                     flash_cnt <= '0;
                  end else if (flash_cnt == 8'(FLASH_PERIOD - 1)) begin
                     flash_cnt <= '0;
                     flash     <= ~flash;
                  end else begin
                     flash_cnt <= flash_cnt + 8'd1;
                  end
               end
            end
            STATE_OVER: begin
               if (start_edge) state <= STATE_IDLE;
            end
            default: state <= STATE_IDLE;
         endcase
      end
   end

   assign bus.GAME_STATE      = state;
   assign bus.SCROLL_EN       = scroll_en;
   assign bus.SCORE           = score;
   assign bus.LIVES           = lives;
   assign bus.FLASH           = flash;
   assign bus.GAME_OVER_PULSE = over_pulse;

endmodule

// File: tb/tb_collision_game_state_ctrl.sv
// Bench for collision_game_state_ctrl: directed game scenarios then random play,
// every cycle compared against a frame-level behavioural model of the game rules.
module tb_collision_game_state_ctrl;

   localparam int NB   = 4;
   localparam int HC   = 2;
   localparam int INV  = 60;
   localparam int IL   = 3;
   localparam int SW   = 10;
   localparam int FP   = 8;
   localparam int SMAX = (1 << SW) - 1;

   localparam int M_IDLE = 0;
   localparam int M_PLAY = 1;
   localparam int M_HIT  = 2;
   localparam int M_OVER = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   collision_game_state_ctrl_if #(.NUM_BLOCKS(NB), .SCORE_WIDTH(SW)) bus ();

   collision_game_state_ctrl #(
      .NUM_BLOCKS        (NB),
      .HIT_CONFIRM       (HC),
      .INVINCIBLE_FRAMES (INV),
      .INIT_LIVES        (IL),
      .SCORE_WIDTH       (SW),
      .FLASH_PERIOD      (FP)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus.slave)
   );

   int checks = 0;
   int passes = 0;

   int m_mode, m_lives, m_score, m_streak, m_inv_left, m_hit_ticks, m_pulse, m_key_prev;
   bit key_level = 1'b0;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_update(input bit r, input bit tick, input bit key,
                               input logic [3:0] ovl, input logic [3:0] pass);
      bit edge_seen;
      int sum;
      if (r) begin
         m_mode = M_IDLE; m_lives = IL; m_score = 0; m_streak = 0;
         m_inv_left = 0; m_hit_ticks = 0; m_pulse = 0; m_key_prev = key;
         return;
      end
      edge_seen  = key && (m_key_prev == 0);
      m_key_prev = key;
      m_pulse    = 0;
      sum        = m_score + $countones(pass);
      case (m_mode)
         M_IDLE: if (edge_seen) begin
            m_mode = M_PLAY; m_lives = IL; m_score = 0; m_streak = 0;
         end
         M_PLAY: if (tick) begin
            m_score  = (sum > SMAX) ? SMAX : sum;
            m_streak = (ovl != 0) ? m_streak + 1 : 0;
            if (m_streak == HC) begin
               m_streak = 0;
               m_lives--;
               if (m_lives == 0) begin
                  m_mode = M_OVER; m_pulse = 1;
               end else begin
                  m_mode = M_HIT; m_inv_left = INV; m_hit_ticks = 0;
               end
            end
         end
         M_HIT: if (tick) begin
            m_score = (sum > SMAX) ? SMAX : sum;
            m_inv_left--;
            m_hit_ticks++;
            if (m_inv_left == 0) m_mode = M_PLAY;
         end
         default: if (edge_seen) m_mode = M_IDLE;
      endcase
   endtask

   task automatic step(input bit r, input bit tick, input bit key,
                       input logic [3:0] ovl, input logic [3:0] pass);
      int exp_flash;
      rst                    = r;
      bus.FRAME_TICK         = tick;
      bus.START_KEY          = key;
      bus.IS_OVERLAPPING_VEC = ovl;
      bus.BLOCK_PASSED_VEC   = pass;
      key_level              = key;
      model_update(r, tick, key, ovl, pass);
      @(posedge clk);
      #1;
      exp_flash = (m_mode == M_HIT) ? ((m_hit_ticks / FP) % 2) : 0;
      check_eq("state",  int'(bus.GAME_STATE),      m_mode);
      check_eq("scroll", int'(bus.SCROLL_EN),       int'(m_mode == M_PLAY || m_mode == M_HIT));
      check_eq("score",  int'(bus.SCORE),           m_score);
      check_eq("lives",  int'(bus.LIVES),           m_lives);
      check_eq("flash",  int'(bus.FLASH),           exp_flash);
      check_eq("pulse",  int'(bus.GAME_OVER_PULSE), m_pulse);
   endtask

   // One sampled frame followed by one quiet cycle.
   task automatic frame(input logic [3:0] ovl, input logic [3:0] pass);
      step(1'b0, 1'b1, key_level, ovl, pass);
      step(1'b0, 1'b0, key_level, 4'b0000, 4'b0000);
   endtask

   task automatic press();
      step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
      step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
   endtask

   initial begin
      bus.FRAME_TICK = 1'b0; bus.START_KEY = 1'b0;
      bus.IS_OVERLAPPING_VEC = '0; bus.BLOCK_PASSED_VEC = '0;

      step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
      step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
      check_eq("rst_lives", int'(bus.LIVES), 3);

      press();
      check_eq("t1_state", int'(bus.GAME_STATE), 1);
      check_eq("t1_lives", int'(bus.LIVES), 3);

      frame(4'b0100, 4'b0000);
      frame(4'b0000, 4'b0000);
      check_eq("t2_nolose", int'(bus.LIVES), 3);
      frame(4'b0100, 4'b0000);
      frame(4'b0100, 4'b0000);
      check_eq("t2_hit", int'(bus.GAME_STATE), 2);
      check_eq("t2_lives", int'(bus.LIVES), 2);
      for (int i = 0; i < 8; i++) frame(4'b0100, 4'b0001);
      check_eq("t2_flash", int'(bus.FLASH), 1);

      for (int i = 8; i < INV; i++) frame(4'b0100, 4'b0000);
      check_eq("t3_back", int'(bus.GAME_STATE), 1);
      check_eq("t3_lives_held", int'(bus.LIVES), 2);
      frame(4'b0100, 4'b0000);
      frame(4'b0100, 4'b0000);
      check_eq("t3_lives", int'(bus.LIVES), 1);

      for (int i = 0; i < INV; i++) frame(4'b0000, 4'b0000);
      frame(4'b1000, 4'b0000);
      step(1'b0, 1'b1, 1'b0, 4'b1000, 4'b0011);
      check_eq("t4_over", int'(bus.GAME_STATE), 3);
      check_eq("t4_pulse", int'(bus.GAME_OVER_PULSE), 1);
      check_eq("t4_score", int'(bus.SCORE), 10);
      step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
      check_eq("t4_pulse_end", int'(bus.GAME_OVER_PULSE), 0);
      frame(4'b1111, 4'b1111);
      check_eq("t4_frozen", int'(bus.SCORE), 10);

      press();
      check_eq("t4_idle", int'(bus.GAME_STATE), 0);
      press();
      for (int i = 0; i < 255; i++) frame(4'b0000, 4'b1111);
      frame(4'b0000, 4'b0011);
      check_eq("t5_1022", int'(bus.SCORE), 1022);
      frame(4'b0000, 4'b1111);
      check_eq("t5_sat", int'(bus.SCORE), 1023);
      frame(4'b0000, 4'b1111);
      check_eq("t5_hold", int'(bus.SCORE), 1023);

      frame(4'b0001, 4'b0000);
      frame(4'b0001, 4'b0000);
      for (int i = 0; i < 30; i++) frame(4'b0000, 4'b0000);
      step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
      check_eq("t6_idle", int'(bus.GAME_STATE), 0);
      check_eq("t6_score", int'(bus.SCORE), 0);
      step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
      check_eq("t6_held", int'(bus.GAME_STATE), 0);
      press();
      check_eq("t6_start", int'(bus.GAME_STATE), 1);

      for (int i = 0; i < 3000; i++) begin
         bit r, t, k;
         logic [3:0] o, p;
         r = ($urandom_range(0, 599) == 0);
         t = ($urandom_range(0, 2) == 0);
         k = ($urandom_range(0, 39) == 0) ? ~key_level : key_level;
         o = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         p = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
         step(r, t, k, o, p);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
